// File: rtl/algo_hsv_mask_multi.sv
// algo_hsv_mask_multi: per-channel HSV window masking with frame-swapped thresholds and per-frame hit statistics
module algo_hsv_mask_multi #(
  parameter int N_CH  = 4,
  parameter int X_W   = 11,
  parameter int Y_W   = 11,
  parameter int CNT_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vs,
  input  logic             i_hs,
  input  logic             i_data_en,
  input  logic [7:0]       i_h_8b,
  input  logic [7:0]       i_s_8b,
  input  logic [7:0]       i_v_8b,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_ch,
  input  logic [2:0]       cfg_addr,
  input  logic [7:0]       cfg_wdata,
  input  logic [2:0]       i_stat_ch,
  output logic             o_vs,
  output logic             o_hs,
  output logic             o_data_en,
  output logic [N_CH-1:0]  o_mask,
  output logic             o_stat_valid,
  output logic             o_stat_hit,
  output logic [CNT_W-1:0] o_stat_cnt,
  output logic [X_W-1:0]   o_xmin,
  output logic [X_W-1:0]   o_xmax,
  output logic [Y_W-1:0]   o_ymin,
  output logic [Y_W-1:0]   o_ymax
);
  typedef enum logic {WAIT_FRAME, RUN} state_t;
  state_t state_q, state_d;
  logic vs_prev_q, hs_prev_q, vs_rise, hs_fall, latch, stat_valid_q, line_px_q;
  logic [1:0] vs_q, hs_q, de_q;
  logic [N_CH-1:0] hit, m1_q, m2_q, sh_en_q, act_en_q;
  logic [7:0] sh_q [N_CH][6];
  logic [7:0] act_q [N_CH][6];
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic [CNT_W-1:0] acc_cnt_q [N_CH];
  logic [CNT_W-1:0] res_cnt_q [N_CH];
  logic [X_W-1:0] acc_xmin_q [N_CH];
  logic [X_W-1:0] acc_xmax_q [N_CH];
  logic [X_W-1:0] res_xmin_q [N_CH];
  logic [X_W-1:0] res_xmax_q [N_CH];
  logic [Y_W-1:0] acc_ymin_q [N_CH];
  logic [Y_W-1:0] acc_ymax_q [N_CH];
  logic [Y_W-1:0] res_ymin_q [N_CH];
  logic [Y_W-1:0] res_ymax_q [N_CH];

  assign vs_rise = i_vs & ~vs_prev_q;
  assign hs_fall = hs_prev_q & ~i_hs;

  always_ff @(posedge clk)
    state_q <= rst ? WAIT_FRAME : state_d;

  always_comb state_d = vs_rise ? RUN : state_q;

  always_comb latch = (state_q == RUN) && vs_rise;

  // hue window wraps through 0 when hmin > hmax
  always_comb begin
    hit = '0;
    for (int c = 0; c < N_CH; c++)
      hit[c] = i_data_en && act_en_q[c]
        && ((act_q[c][0] <= act_q[c][1])
            ? (i_h_8b >= act_q[c][0] && i_h_8b <= act_q[c][1])
            : (i_h_8b >= act_q[c][0] || i_h_8b <= act_q[c][1]))
        && i_s_8b >= act_q[c][2] && i_s_8b <= act_q[c][3]
        && i_v_8b >= act_q[c][4] && i_v_8b <= act_q[c][5];
  end

  always_ff @(posedge clk)
    if (rst) begin
      {vs_prev_q, hs_prev_q, stat_valid_q} <= '0;
      {vs_q, hs_q, de_q} <= '0;
      {m1_q, m2_q, sh_en_q, act_en_q} <= '0;
      for (int c = 0; c < N_CH; c++)
        for (int a = 0; a < 6; a++) begin
          sh_q[c][a]  <= {8{a[0]}};
          act_q[c][a] <= {8{a[0]}};
        end
    end else begin
      vs_prev_q    <= i_vs;
      hs_prev_q    <= i_hs;
      stat_valid_q <= latch;
      vs_q <= {vs_q[0], i_vs};
      hs_q <= {hs_q[0], i_hs};
      de_q <= {de_q[0], i_data_en};
      m1_q <= hit;
      m2_q <= m1_q;
      for (int c = 0; c < N_CH; c++) begin
        if (vs_rise) begin
          act_en_q[c] <= sh_en_q[c];
          for (int a = 0; a < 6; a++) act_q[c][a] <= sh_q[c][a];
        end
        if (cfg_we && cfg_ch == 3'(c)) begin
          if (cfg_addr == 3'd6) sh_en_q[c] <= cfg_wdata[0];
          else if (cfg_addr != 3'd7) sh_q[c][cfg_addr] <= cfg_wdata;
        end
      end
    end

  always_ff @(posedge clk)
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      line_px_q <= 1'b0;
    end else begin
      x_q <= !i_hs ? '0 : (i_data_en && x_q != '1) ? x_q + 1'b1 : x_q;
      y_q <= vs_rise ? '0 : (hs_fall && line_px_q && y_q != '1) ? y_q + 1'b1 : y_q;
      line_px_q <= (vs_rise || hs_fall) ? i_data_en : line_px_q | i_data_en;
    end

  // boundary-cycle pixel is excluded from the frame being latched
  always_ff @(posedge clk)
    for (int c = 0; c < N_CH; c++)
      if (rst || vs_rise) begin
        if (rst) begin
          res_cnt_q[c]  <= '0;
          res_xmin_q[c] <= '1;
          res_xmax_q[c] <= '0;
          res_ymin_q[c] <= '1;
          res_ymax_q[c] <= '0;
        end else if (latch) begin
          res_cnt_q[c]  <= acc_cnt_q[c];
          res_xmin_q[c] <= acc_xmin_q[c];
          res_xmax_q[c] <= acc_xmax_q[c];
          res_ymin_q[c] <= acc_ymin_q[c];
          res_ymax_q[c] <= acc_ymax_q[c];
        end
        acc_cnt_q[c]  <= '0;
        acc_xmin_q[c] <= '1;
        acc_xmax_q[c] <= '0;
        acc_ymin_q[c] <= '1;
        acc_ymax_q[c] <= '0;
      end else if (hit[c]) begin
        acc_cnt_q[c]  <= acc_cnt_q[c] == '1 ? acc_cnt_q[c] : acc_cnt_q[c] + 1'b1;
        acc_xmin_q[c] <= x_q < acc_xmin_q[c] ? x_q : acc_xmin_q[c];
        acc_xmax_q[c] <= x_q > acc_xmax_q[c] ? x_q : acc_xmax_q[c];
        acc_ymin_q[c] <= y_q < acc_ymin_q[c] ? y_q : acc_ymin_q[c];
        acc_ymax_q[c] <= y_q > acc_ymax_q[c] ? y_q : acc_ymax_q[c];
      end

  always_comb begin
    o_stat_cnt = '0;
    o_xmin = '0;
    o_xmax = '0;
    o_ymin = '0;
    o_ymax = '0;
    for (int c = 0; c < N_CH; c++)
      if (i_stat_ch == 3'(c)) begin
        o_stat_cnt = res_cnt_q[c];
        o_xmin = res_xmin_q[c];
        o_xmax = res_xmax_q[c];
        o_ymin = res_ymin_q[c];
        o_ymax = res_ymax_q[c];
      end
    o_stat_hit = o_stat_cnt != '0;
  end

  assign o_vs = vs_q[1];
  assign o_hs = hs_q[1];
  assign o_data_en = de_q[1];
  assign o_mask = m2_q;
  assign o_stat_valid = stat_valid_q;
endmodule

// File: tb/tb_algo_hsv_mask_multi.sv
// tb_algo_hsv_mask_multi: random and directed frames checked against a frame-level reference model
module tb_algo_hsv_mask_multi;
  localparam int N_CH = 4, X_W = 11, Y_W = 11, CNT_W = 22;
  localparam int XONES = (1 << X_W) - 1, YONES = (1 << Y_W) - 1;

  logic clk = 1'b0, rst;
  logic i_vs, i_hs, i_data_en, cfg_we;
  logic [7:0] i_h_8b, i_s_8b, i_v_8b, cfg_wdata;
  logic [2:0] cfg_ch, cfg_addr, i_stat_ch;
  logic o_vs, o_hs, o_data_en, o_stat_valid, o_stat_hit;
  logic [N_CH-1:0] o_mask;
  logic [CNT_W-1:0] o_stat_cnt;
  logic [X_W-1:0] o_xmin, o_xmax;
  logic [Y_W-1:0] o_ymin, o_ymax;

  always #10 clk = ~clk;

  algo_hsv_mask_multi #(.N_CH(N_CH), .X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_vs(i_vs), .i_hs(i_hs), .i_data_en(i_data_en),
    .i_h_8b(i_h_8b), .i_s_8b(i_s_8b), .i_v_8b(i_v_8b),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .i_stat_ch(i_stat_ch), .o_vs(o_vs), .o_hs(o_hs), .o_data_en(o_data_en),
    .o_mask(o_mask), .o_stat_valid(o_stat_valid), .o_stat_hit(o_stat_hit),
    .o_stat_cnt(o_stat_cnt), .o_xmin(o_xmin), .o_xmax(o_xmax),
    .o_ymin(o_ymin), .o_ymax(o_ymax));

  int errors = 0, checks = 0, valid_seen = 0;
  int sh [N_CH][7];
  int act [N_CH][7];
  int a_cnt [N_CH], a_xmin [N_CH], a_xmax [N_CH], a_ymin [N_CH], a_ymax [N_CH];
  int r_cnt [N_CH], r_xmin [N_CH], r_xmax [N_CH], r_ymin [N_CH], r_ymax [N_CH];
  bit m_run, m_vsp, rnd_cfg;
  int col, row;
  logic [N_CH+2:0] pq [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit in_win(int c);
    bit hok;
    int h = int'(i_h_8b), s = int'(i_s_8b), v = int'(i_v_8b);
    hok = act[c][0] <= act[c][1] ? (h >= act[c][0] && h <= act[c][1])
                                  : (h >= act[c][0] || h <= act[c][1]);
    return act[c][6] != 0 && hok && s >= act[c][2] && s <= act[c][3]
           && v >= act[c][4] && v <= act[c][5];
  endfunction

  task automatic clear_acc();
    for (int c = 0; c < N_CH; c++) begin
      a_cnt[c] = 0; a_xmin[c] = XONES; a_xmax[c] = 0; a_ymin[c] = YONES; a_ymax[c] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1; i_vs = 0; i_hs = 0; i_data_en = 0; cfg_we = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int c = 0; c < N_CH; c++) begin
      for (int a = 0; a < 7; a++) begin
        sh[c][a] = (a == 6) ? 0 : (a % 2) * 255;
        act[c][a] = sh[c][a];
      end
      r_cnt[c] = 0; r_xmin[c] = XONES; r_xmax[c] = 0; r_ymin[c] = YONES; r_ymax[c] = 0;
    end
    clear_acc();
    m_run = 0; m_vsp = 0;
    pq.delete();
    pq.push_back('0);
  endtask

  task automatic stat_all();
    for (int c = 0; c < 8; c++) begin
      i_stat_ch = 3'(c);
      #1;
      if (c < N_CH) begin
        chk("stat_cnt", o_stat_cnt, r_cnt[c]);
        chk("stat_hit", o_stat_hit, r_cnt[c] != 0);
        chk("stat_xmin", o_xmin, r_xmin[c]);
        chk("stat_xmax", o_xmax, r_xmax[c]);
        chk("stat_ymin", o_ymin, r_ymin[c]);
        chk("stat_ymax", o_ymax, r_ymax[c]);
      end else
        chk("stat_oob", {o_stat_hit, o_stat_cnt, o_xmin, o_xmax, o_ymin, o_ymax}, 0);
    end
    i_stat_ch = 0;
  endtask

  // one clock of stimulus: model the cycle, advance, compare
  task automatic step();
    logic [N_CH-1:0] em;
    bit rise, ev;
    em = '0;
    for (int c = 0; c < N_CH; c++) em[c] = i_data_en && in_win(c);
    rise = i_vs && !m_vsp;
    ev = rise && m_run;
    if (rise) begin
      if (m_run)
        for (int c = 0; c < N_CH; c++) begin
          r_cnt[c] = a_cnt[c]; r_xmin[c] = a_xmin[c]; r_xmax[c] = a_xmax[c];
          r_ymin[c] = a_ymin[c]; r_ymax[c] = a_ymax[c];
        end
      clear_acc();
      act = sh;
      m_run = 1;
    end else
      for (int c = 0; c < N_CH; c++)
        if (em[c]) begin
          a_cnt[c]++;
          if (col < a_xmin[c]) a_xmin[c] = col;
          if (col > a_xmax[c]) a_xmax[c] = col;
          if (row < a_ymin[c]) a_ymin[c] = row;
          if (row > a_ymax[c]) a_ymax[c] = row;
        end
    if (cfg_we && cfg_ch < N_CH && cfg_addr < 7)
      sh[cfg_ch][cfg_addr] = (cfg_addr == 6) ? int'(cfg_wdata[0]) : int'(cfg_wdata);
    m_vsp = i_vs;
    @(posedge clk);
    #1;
    chk("pipe", {o_vs, o_hs, o_data_en, o_mask}, pq.pop_front());
    pq.push_back({i_vs, i_hs, i_data_en, em});
    chk("stat_valid", o_stat_valid, ev);
    if (o_stat_valid) valid_seen++;
    if (ev) stat_all();
  endtask

  task automatic rstep();
    if (rnd_cfg && $urandom_range(15) == 0) begin
      cfg_we = 1; cfg_ch = 3'($urandom_range(7)); cfg_addr = 3'($urandom_range(7));
      cfg_wdata = 8'($urandom);
    end
    step();
    cfg_we = 0;
  endtask

  task automatic cfg_w(input int ch, input int addr, input int data);
    cfg_we = 1; cfg_ch = 3'(ch); cfg_addr = 3'(addr); cfg_wdata = 8'(data);
    i_data_en = 0;
    step();
    cfg_we = 0;
  endtask

  task automatic vsync();
    i_hs = 0; i_data_en = 0;
    rstep();
    i_vs = 1;
    rstep(); rstep();
    i_vs = 0;
    rstep(); rstep();
    row = 0; col = 0;
  endtask

  task automatic endline();
    i_hs = 0; i_data_en = 0;
    repeat (3) rstep();
    if (col > 0) row++;
    col = 0;
  endtask

  task automatic px(input int h, input int s, input int v);
    i_hs = 1; i_data_en = 1;
    i_h_8b = 8'(h); i_s_8b = 8'(s); i_v_8b = 8'(v);
    rstep();
    col++;
    i_data_en = 0;
  endtask

  task automatic pxchk(input string tag, input int h, input int ch, input bit e);
    px(h, 128, 128);
    rstep();
    chk(tag, o_mask[ch], e);
  endtask

  task automatic lines(input int w, input int nl, input bit dir);
    for (int r = 0; r < nl; r++) begin
      i_hs = 1; i_data_en = 0;
      rstep();
      while (col < w)
        if ($urandom_range(3) == 0) begin
          i_data_en = 0;
          rstep();
        end else if (dir)
          px(((col == 2 && row == 1) || (col == 5 && row == 3)) ? 30 : 100, 128, 128);
        else
          px($urandom_range(255), $urandom_range(255), $urandom_range(255));
      endline();
    end
  endtask

  task automatic stat_exp(input string tag, input int cnt, input int xmn, input int xmx,
                          input int ymn, input int ymx, input bit hit);
    i_stat_ch = 0;
    #1;
    chk({tag, "_cnt"}, o_stat_cnt, cnt);
    chk({tag, "_xmin"}, o_xmin, xmn);
    chk({tag, "_xmax"}, o_xmax, xmx);
    chk({tag, "_ymin"}, o_ymin, ymn);
    chk({tag, "_ymax"}, o_ymax, ymx);
    chk({tag, "_hit"}, o_stat_hit, hit);
  endtask

  initial begin
    i_h_8b = 0; i_s_8b = 0; i_v_8b = 0; cfg_ch = 0; cfg_addr = 0; cfg_wdata = 0;
    i_stat_ch = 0; rnd_cfg = 0; col = 0; row = 0;
    do_reset();
    chk("rst_valid", o_stat_valid, 0);
    chk("rst_out", {o_vs, o_hs, o_data_en, o_mask}, 0);
    chk("rst_cnt", o_stat_cnt, 0);
    chk("rst_xmax", o_xmax, 0);
    cfg_w(0, 0, 20); cfg_w(0, 1, 40); cfg_w(0, 6, 1);
    cfg_w(1, 0, 240); cfg_w(1, 1, 10); cfg_w(1, 6, 1);
    vsync();
    chk("first_vs_no_valid", valid_seen, 0);
    i_hs = 1; rstep();
    pxchk("h19", 19, 0, 0); pxchk("h20", 20, 0, 1);
    pxchk("h40", 40, 0, 1); pxchk("h41", 41, 0, 0);
    pxchk("wrap250", 250, 1, 1); pxchk("wrap5", 5, 1, 1);
    pxchk("wrap11", 11, 1, 0); pxchk("wrap239", 239, 1, 0);
    cfg_w(0, 0, 35);
    pxchk("midframe_old", 30, 0, 1);
    endline();
    vsync();
    i_hs = 1; rstep();
    pxchk("newframe_new", 30, 0, 0);
    endline();
    cfg_w(0, 0, 20);
    vsync();
    lines(8, 4, 1);
    vsync();
    stat_exp("frame8x4", 2, 2, 5, 1, 3, 1);
    i_hs = 1; rstep();
    px(30, 128, 128); px(30, 128, 128);
    do_reset();
    valid_seen = 0;
    vsync();
    chk("rst_first_vs_no_valid", valid_seen, 0);
    lines(6, 3, 0);
    vsync();
    chk("rst_second_vs_valid", valid_seen, 1);
    stat_exp("zero_hit", 0, XONES, 0, YONES, 0, 0);
    rnd_cfg = 1;
    for (int c = 0; c < N_CH; c++) begin
      cfg_w(c, 0, $urandom_range(255)); cfg_w(c, 1, $urandom_range(255));
      cfg_w(c, 2, $urandom_range(100)); cfg_w(c, 3, $urandom_range(255, 150));
      cfg_w(c, 4, $urandom_range(100)); cfg_w(c, 5, $urandom_range(255, 150));
      cfg_w(c, 6, 1);
    end
    vsync();
    for (int f = 0; f < 8; f++) begin
      lines(12, 5, 0);
      vsync();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
